// File: rtl/lap_stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// lap_stopwatch_pkg : shared types, constants and helpers for lap_stopwatch
// Revision 1.0
// ============================================================================
package lap_stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  // Active-high pattern for '0', bit order {a,b,c,d,e,f,g}
  localparam logic [SEG_W-1:0] SEG_PAT_ZERO = 7'b1111110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic int clog2(input longint unsigned v);
    int              r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lap_stopwatch_bcd_digit.sv
`default_nettype none
// ============================================================================
// bcd_digit : one registered up/down BCD digit with carry/borrow chaining
// Revision 1.0
// ============================================================================
module bcd_digit
  import lap_stopwatch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             cin_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             cout_o
);

  logic [BCD_W-1:0] digit_q, digit_d;
  logic             w_at_limit;

  assign w_at_limit = up_i ? (digit_q == 4'd9) : (digit_q == 4'd0);
  assign cout_o     = cin_i & w_at_limit;
  assign digit_o    = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (en_i && cin_i) begin
      if (w_at_limit) digit_d = up_i ? 4'd0 : 4'd9;
      else            digit_d = up_i ? digit_q + 4'd1 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) digit_q <= '0;
    else         digit_q <= digit_d;
  end

endmodule
`default_nettype wire

// File: rtl/lap_stopwatch.sv
`default_nettype none
// ============================================================================
// lap_stopwatch : N-digit BCD up/down stopwatch with lap freeze, prescaler or
//                 external step, and registered 7-segment output
// Revision 1.0
// ============================================================================
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int BASE_DIV   = 50000,
  parameter int SPEED_W    = 5,
  parameter bit SEG_ACT_LO = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_stop_i,
  input  logic                      lap_i,
  input  logic                      clear_i,
  input  logic                      dir_i,
  input  logic                      clk_sel_i,
  input  logic                      step_i,
  input  logic [SPEED_W-1:0]        speed_i,
  output logic [BCD_W*N_DIGITS-1:0] digits_o,
  output logic [SEG_W*N_DIGITS-1:0] seg_o,
  output logic [1:0]                state_o,
  output logic                      running_o,
  output logic                      tick_o,
  output logic                      wrap_o,
  output logic                      done_o
);

  localparam int CNT_W   = BCD_W * N_DIGITS;
  localparam int SEGS_W  = SEG_W * N_DIGITS;
  localparam int PRESC_W = clog2(longint'(BASE_DIV) * (longint'(1) << SPEED_W) + 1);
  localparam logic [SEG_W-1:0] SEG_ZERO = SEG_ACT_LO ? ~SEG_PAT_ZERO : SEG_PAT_ZERO;

  state_t             state_q, state_d;
  logic               running_q;
  logic               frozen_q, frozen_d;
  logic [CNT_W-1:0]   lap_q, lap_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic               clk_sel_q;
  logic               pending_q;
  logic               tick_q, wrap_q, done_q;
  logic [SEGS_W-1:0]  seg_q;

  logic [CNT_W-1:0]   w_count;
  logic [N_DIGITS:0]  w_carry;
  logic               w_count_zero, w_count_one;
  logic               w_presc_term, w_tick, w_apply, w_wrap, w_done;
  logic [CNT_W-1:0]   w_disp;
  logic [SEGS_W-1:0]  w_seg;

  assign w_carry[0] = 1'b1;
  assign w_disp     = frozen_q ? lap_q : w_count;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [SEG_W-1:0] w_pat;

    bcd_digit u_digit (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clear_i),
      .en_i    (w_apply),
      .up_i    (~dir_i),
      .cin_i   (w_carry[gi]),
      .digit_o (w_count[gi*BCD_W +: BCD_W]),
      .cout_o  (w_carry[gi+1])
    );

    assign w_pat                    = bcd_to_seg(w_disp[gi*BCD_W +: BCD_W]);
    assign w_seg[gi*SEG_W +: SEG_W] = SEG_ACT_LO ? ~w_pat : w_pat;
  end

  assign w_count_zero = (w_count == '0);
  assign w_count_one  = (w_count == CNT_W'(1));

  // A freshly changed ClkSel never produces an internal tick in the same cycle
  assign w_presc_term = ~clk_sel_i && (clk_sel_i == clk_sel_q) &&
                        (presc_q == period_q - PRESC_W'(1));
  assign w_tick  = running_q && (clk_sel_i ? step_i : w_presc_term);
  assign w_apply = pending_q && ~clear_i && ~(dir_i && w_count_zero);
  assign w_wrap  = w_apply && ~dir_i && w_carry[N_DIGITS];
  assign w_done  = w_apply && dir_i && w_count_one;

  always_comb begin
    presc_d  = presc_q;
    period_d = period_q;
    if (clear_i || clk_sel_i || (clk_sel_i != clk_sel_q)) presc_d = '0;
    else if (running_q) presc_d = w_presc_term ? '0 : presc_q + PRESC_W'(1);
    if (!running_q || clk_sel_i || w_presc_term)
      period_d = PRESC_W'(BASE_DIV) * (PRESC_W'(speed_i) + PRESC_W'(1));
  end

  // Clear beats a completing countdown, which beats StartStop, which beats Lap
  always_comb begin
    state_d  = state_q;
    frozen_d = frozen_q;
    lap_d    = lap_q;
    if (clear_i) begin
      state_d  = ST_IDLE;
      frozen_d = 1'b0;
      lap_d    = '0;
    end else if (w_done) begin
      state_d = ST_PAUSE;
    end else if (start_stop_i) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: state_d = ST_RUN;
        default:           state_d = ST_PAUSE;
      endcase
    end else if (lap_i) begin
      case (state_q)
        ST_RUN: begin
          state_d  = ST_LAP;
          frozen_d = 1'b1;
          lap_d    = w_count;
        end
        ST_LAP: begin
          state_d  = ST_RUN;
          frozen_d = 1'b0;
        end
        ST_PAUSE: frozen_d = 1'b0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      frozen_q  <= 1'b0;
      lap_q     <= '0;
      presc_q   <= '0;
      period_q  <= PRESC_W'(BASE_DIV);
      clk_sel_q <= 1'b0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_q     <= {N_DIGITS{SEG_ZERO}};
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN) || (state_d == ST_LAP);
      frozen_q  <= frozen_d;
      lap_q     <= lap_d;
      presc_q   <= presc_d;
      period_q  <= period_d;
      clk_sel_q <= clk_sel_i;
      pending_q <= w_tick & ~clear_i;
      tick_q    <= w_apply;
      wrap_q    <= w_wrap;
      done_q    <= w_done;
      seg_q     <= w_seg;
    end
  end

  assign digits_o  = w_count;
  assign seg_o     = seg_q;
  assign state_o   = state_q;
  assign running_o = running_q;
  assign tick_o    = tick_q;
  assign wrap_o    = wrap_q;
  assign done_o    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
`default_nettype none
// ============================================================================
// tb_lap_stopwatch : scoreboard bench for lap_stopwatch (4 digits, BASE_DIV=4)
// Revision 1.0
// ============================================================================
module tb_lap_stopwatch;

  localparam int N_DIGITS = 4;
  localparam int BASE_DIV = 4;
  localparam int SPEED_W  = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ss = 1'b0, lp = 1'b0, clr = 1'b0, dir = 1'b0, csel = 1'b0, step = 1'b0;
  logic [SPEED_W-1:0] speed = '0;
  logic [15:0]        digits;
  logic [27:0]        seg;
  logic [1:0]         state;
  logic               running, tick, wrap, done;

  lap_stopwatch #(
    .N_DIGITS   (N_DIGITS),
    .BASE_DIV   (BASE_DIV),
    .SPEED_W    (SPEED_W),
    .SEG_ACT_LO (1'b1)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_stop_i (ss),
    .lap_i        (lp),
    .clear_i      (clr),
    .dir_i        (dir),
    .clk_sel_i    (csel),
    .step_i       (step),
    .speed_i      (speed),
    .digits_o     (digits),
    .seg_o        (seg),
    .state_o      (state),
    .running_o    (running),
    .tick_o       (tick),
    .wrap_o       (wrap),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_digit(input int d);
    case (d)
      0: return ~7'b1111110;
      1: return ~7'b0110000;
      2: return ~7'b1101101;
      3: return ~7'b1111001;
      4: return ~7'b0110011;
      5: return ~7'b1011011;
      6: return ~7'b1011111;
      7: return ~7'b1110000;
      8: return ~7'b1111111;
      9: return ~7'b1111011;
      default: return ~7'b0000000;
    endcase
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] b;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      b[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic logic [27:0] seg_of(input logic [15:0] b);
    logic [27:0] s;
    for (int i = 0; i < 4; i++) s[i*7 +: 7] = seg_digit(int'(b[i*4 +: 4]));
    return s;
  endfunction

  // Behavioural reference: decimal count, one call per clock edge
  int m_state, m_cnt, m_lap, m_presc, m_period, m_segval;
  bit m_frozen, m_csel_prev, m_pending, m_running, m_tick, m_wrap, m_done;

  task automatic model_step();
    int disp, n_cnt;
    bit run_now, term, tk, apply;
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_lap = 0; m_presc = 0; m_period = BASE_DIV; m_segval = 0;
      m_frozen = 0; m_csel_prev = 0; m_pending = 0; m_running = 0;
      m_tick = 0; m_wrap = 0; m_done = 0;
    end else begin
      disp    = m_frozen ? m_lap : m_cnt;
      run_now = (m_state == 1) || (m_state == 3);
      term    = !csel && (csel == m_csel_prev) && (m_presc == m_period - 1);
      tk      = run_now && (csel ? step : term);
      apply   = m_pending && !clr && !(dir && m_cnt == 0);
      n_cnt = m_cnt; m_wrap = 0; m_done = 0;
      if (clr) n_cnt = 0;
      else if (apply) begin
        if (!dir) begin
          if (m_cnt == 9999) begin n_cnt = 0; m_wrap = 1; end
          else n_cnt = m_cnt + 1;
        end else begin
          n_cnt  = m_cnt - 1;
          m_done = (n_cnt == 0);
        end
      end
      if (clr) begin
        m_state = 0; m_frozen = 0; m_lap = 0;
      end else if (m_done) begin
        m_state = 2;
      end else if (ss) begin
        m_state = (m_state == 0 || m_state == 2) ? 1 : 2;
      end else if (lp) begin
        if (m_state == 1) begin m_state = 3; m_frozen = 1; m_lap = m_cnt; end
        else if (m_state == 3) begin m_state = 1; m_frozen = 0; end
        else if (m_state == 2) m_frozen = 0;
      end
      if (clr || csel || csel != m_csel_prev) m_presc = 0;
      else if (run_now) m_presc = term ? 0 : m_presc + 1;
      if (!run_now || csel || term) m_period = BASE_DIV * (int'(speed) + 1);
      m_csel_prev = csel;
      m_pending   = tk && !clr;
      m_tick      = apply;
      m_running   = (m_state == 1) || (m_state == 3);
      m_segval    = disp;
      m_cnt       = n_cnt;
    end
  endtask

  typedef struct {
    logic [15:0] digits;
    logic [27:0] seg;
    logic [1:0]  state;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb_q[$];

  task automatic cycle(input logic p_ss, input logic p_lap, input logic p_clr, input logic p_step);
    exp_t e;
    ss = p_ss; lp = p_lap; clr = p_clr; step = p_step;
    model_step();
    e.digits = bcd_of(m_cnt);
    e.seg    = seg_of(bcd_of(m_segval));
    e.state  = 2'(m_state);
    e.flags  = {m_running, m_tick, m_wrap, m_done};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    ss = 0; lp = 0; clr = 0; step = 0;
    e = sb_q.pop_front();
    check_eq("sb_digits", digits, e.digits);
    check_eq("sb_seg", seg, e.seg);
    check_eq("sb_state", state, e.state);
    check_eq("sb_run_tick_wrap_done", {running, tick, wrap, done}, e.flags);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0;
    idle(2);
    rst_n = 1;
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_digits", digits, 16'h0000);
    check_eq("rst_seg", seg, {4{7'b0000001}});
    check_eq("rst_pulses", {running, tick, wrap, done}, 4'b0000);

    cycle(1, 0, 0, 0);
    idle(41);
    check_eq("run_40", digits, 16'h0010);

    cycle(1, 0, 0, 0);
    speed = 5'd1;
    cycle(1, 0, 0, 0);
    idle(40);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);

    csel = 1;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 9999; i++) cycle(0, 0, 0, 1);
    idle(1);
    check_eq("preload_9999", digits, 16'h9999);
    cycle(0, 0, 0, 1);
    idle(1);
    check_eq("wrap_pulse", {wrap, digits}, {1'b1, 16'h0000});
    idle(1);
    check_eq("wrap_once", wrap, 1'b0);

    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    idle(1);
    check_eq("pre_lap", digits, 16'h0005);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    idle(1);
    check_eq("lap_live", digits, 16'h0008);
    check_eq("lap_frozen_seg", seg, seg_of(16'h0005));
    check_eq("lap_state", state, 2'd3);
    cycle(0, 1, 0, 0);
    idle(1);
    check_eq("unlap_seg", seg, seg_of(16'h0008));
    check_eq("unlap_state", state, 2'd1);

    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1);
    idle(1);
    check_eq("down_start", digits, 16'h0002);
    dir = 1;
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1);
    idle(1);
    check_eq("done_pulse", {done, state, digits}, {1'b1, 2'd2, 16'h0000});
    idle(1);
    check_eq("done_once", done, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    idle(1);
    check_eq("done_hold", {state, digits}, {2'd2, 16'h0000});

    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    idle(1);
    check_eq("zero_down", {tick, done, state, digits}, {1'b0, 1'b0, 2'd1, 16'h0000});

    cycle(1, 0, 1, 0);
    check_eq("clr_ss", {state, digits}, {2'd0, 16'h0000});

    dir = 0; csel = 0; speed = 0;
    cycle(1, 0, 0, 0);
    idle(6);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    check_eq("midrun_rst", {running, state, digits}, {1'b0, 2'd0, 16'h0000});
    cycle(1, 0, 0, 0);
    idle(4);
    check_eq("presc_zero_a", {tick, digits}, {1'b0, 16'h0000});
    idle(1);
    check_eq("presc_zero_b", {tick, digits}, {1'b1, 16'h0001});

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) csel = ~csel;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      if ($urandom_range(0, 49) == 0) speed = 5'($urandom_range(0, 2));
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
